mem_port_arbiter: RTL
=====================

// Module: mem_port_arbiter
// PURPOSE
//  Shares the single main-memory port between the instruction cache (port I) and the data cache (port D).
//  Sits between the two cache instances' miss-service memory interfaces and the memory model.
//  Grants the port to one cache for an entire miss service: writeback of up to one line, then refill of one line.
//  Round-robin between the caches; a hold counter detects runaway bursts.
// PARAMETERS
//  AW          32  address width (cache MAddr)
//  DW          32  data width (MWD/MRD)
//  LINE_WORDS  4   words per cache block; max legal beats per grant = 2*LINE_WORDS
//  FIRST_D     1   round-robin pointer after reset: 1 = D wins first tie, 0 = I wins
// PORTS
//  CLK      in   1   clock, all state on rising edge
//  Reset    in   1   synchronous, active-high
//  I_Req    in   1   I-cache requests memory; held high for whole miss service
//  I_Addr   in   AW  I-cache word address; stable until I_Ready
//  I_WE     in   1   I-cache write (never expected; passed through)
//  I_WD     in   DW  I-cache write data
//  I_Ready  out  1   beat done for I; I_RD valid this cycle
//  I_RD     out  DW  read data to I-cache
//  D_Req, D_Addr, D_WE, D_WD, D_Ready, D_RD   same as the I_* ports, for the D-cache
//  MReq     out  1   transfer request to memory
//  MAddr    out  AW  memory address
//  MWE      out  1   memory write enable
//  MWD      out  DW  memory write data
//  MReady   in   1   one-cycle pulse; beat complete; MRD valid
//  MRD      in   DW  memory read data
//  Owner    out  2   00 none, 01 I, 10 D (debug/stall logic)
//  Err      out  1   sticky protocol error
// BEHAVIOUR
//  State machine: IDLE, OWN_I, OWN_D, TURN. All state registered.
//  Reset values: state=IDLE, last_grant=I if FIRST_D else D, beats=0, Err=0.
//  Outputs in IDLE and TURN: MReq=0, MAddr=0, MWE=0, MWD=0, I/D_Ready=0, I/D_RD=0, Owner=00.
//  IDLE: sample I_Req/D_Req.
//   - Only one requester high: grant it next cycle.
//   - Both high: grant the port that is not last_grant.
//   - Neither high: stay IDLE.
//   - Latency: Req high at edge n -> MReq high in cycle n+1.
//  OWN_x:
//   - MReq=x_Req; MAddr/MWE/MWD=x_* combinationally; x_Ready=MReady; x_RD=MRD.
//   - Other port: Ready=0, RD=0.
//   - Other port's Req is ignored (no preemption).
//  Release from OWN_x: x_Req=0 in a cycle with MReady=0 -> TURN; last_grant<=x; beats<=0.
//   - x_Req=0 while MReady=1: completes the beat first; release is evaluated next cycle.
//  TURN: exactly one dead cycle (MReq=0), applies the IDLE arbitration rule, then IDLE or OWN_y.
//   - Back-to-back misses alternate I/D; minimum gap between grants = 1 cycle.
//  beats: width clog2(2*LINE_WORDS+1); +1 per MReady in OWN_x; saturates.
//   - Err<=1 when beats would exceed 2*LINE_WORDS.
//   - Err<=1 when MReady=1 in IDLE or TURN (beat ignored, no Ready forwarded).
//   - Err clears only on Reset.
//  Simultaneous: both Req rise in the same cycle -> round-robin; new Req from owner during TURN -> loses to waiting other port.
//  Reset mid-burst: next edge IDLE, MReq=0; in-flight beat dropped (memory is reset by the same Reset).
// STRUCTURE
//  Package mem_arb_pkg: state encoding (IDLE=2'd0, OWN_I=2'd1, OWN_D=2'd2, TURN=2'd3), owner codes, OWNER_NONE/I/D.
//  Sub-module arb_pick2: combinational 2-way round-robin pick (req_i, req_d, last_grant -> grant_d, any).
//   - Used by both IDLE and TURN.
//  Top: FSM, beat counter, Err flag, port muxes.
// TESTING
//  1. Reset, D_Req=1 only, memory 3-cycle latency, 4 reads at 0x100..0x10C:
//     MReq in cycle 2, D_Ready x4, D_RD = memory data, I_Ready stays 0, Owner=10.
//  2. I_Req and D_Req rise same cycle after reset (FIRST_D=1):
//     D granted first; on D release, TURN 1 cycle, then I granted; Owner 10 -> 00 -> 01.
//  3. D writeback + refill: 4 writes MWE=1 to 0x2C0.., then 4 reads:
//     8 beats, Err=0, MWD equals D_WD on each beat.
//  4. Owner holds 9 beats (LINE_WORDS=4): Err=1 on 9th MReady, stays 1 until Reset.
//  5. Stray MReady in IDLE: Err=1, I_Ready=D_Ready=0.
//  6. Reset asserted during 2nd beat of I refill: next cycle Owner=00, MReq=0, beats=0, Err=0;
//     new D_Req granted normally.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the I/D main-memory port arbiter: FSM states, grant
// identities and the owner codes reported to stall/debug logic.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN_I = 2'd1,
    OWN_D = 2'd2,
    TURN  = 2'd3
  } arb_state_e;

  typedef enum logic {
    GRANT_I = 1'b0,
    GRANT_D = 1'b1
  } grant_e;

  localparam logic [1:0] OWNER_NONE = 2'b00;
  localparam logic [1:0] OWNER_I    = 2'b01;
  localparam logic [1:0] OWNER_D    = 2'b10;

  function automatic logic [1:0] owner_of(arb_state_e s);
    logic [1:0] code;
    code = OWNER_NONE;
    case (s)
      OWN_I:   code = OWNER_I;
      OWN_D:   code = OWNER_D;
      default: code = OWNER_NONE;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the two cache miss-service ports, the memory port and the
// arbiter status outputs; slave is the arbiter side, master the environment.
interface mem_port_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);

  logic          i_req;
  logic [AW-1:0] i_addr;
  logic          i_we;
  logic [DW-1:0] i_wd;
  logic          i_ready;
  logic [DW-1:0] i_rd;

  logic          d_req;
  logic [AW-1:0] d_addr;
  logic          d_we;
  logic [DW-1:0] d_wd;
  logic          d_ready;
  logic [DW-1:0] d_rd;

  logic          mreq;
  logic [AW-1:0] maddr;
  logic          mwe;
  logic [DW-1:0] mwd;
  logic          mready;
  logic [DW-1:0] mrd;

  logic [1:0]    owner;
  logic          err;

  modport slave (
    input  i_req, i_addr, i_we, i_wd,
    input  d_req, d_addr, d_we, d_wd,
    input  mready, mrd,
    output i_ready, i_rd, d_ready, d_rd,
    output mreq, maddr, mwe, mwd,
    output owner, err
  );

  modport master (
    output i_req, i_addr, i_we, i_wd,
    output d_req, d_addr, d_we, d_wd,
    output mready, mrd,
    input  i_ready, i_rd, d_ready, d_rd,
    input  mreq, maddr, mwe, mwd,
    input  owner, err
  );

endinterface

// File: rtl/mem_port_arbiter_pick2.sv
// Two-way round-robin pick: a lone requester wins, a tie goes to the port
// that did not hold the previous grant.
module arb_pick2
  import mem_arb_pkg::*;
(
  input  logic   req_i,
  input  logic   req_d,
  input  grant_e last_grant,
  output logic   grant_d,
  output logic   any
);

  assign any     = req_i | req_d;
  assign grant_d = req_d & (~req_i | (last_grant == GRANT_I));

endmodule

// File: rtl/mem_port_arbiter.sv
// Main-memory port arbiter: grants the port to the I or D cache for a whole
// miss service, inserts one dead cycle between grants, flags protocol errors.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int LINE_WORDS = 4,
  parameter int FIRST_D    = 1
) (
  input logic               clk,
  input logic               reset,
  mem_port_arbiter_if.slave bus
);

  localparam int MAX_BEATS = 2 * LINE_WORDS;
  localparam int BW        = $clog2(MAX_BEATS + 1);
  localparam logic [BW-1:0] MAX_BEATS_W = BW'(MAX_BEATS);
  localparam grant_e LAST_RESET = (FIRST_D != 0) ? GRANT_I : GRANT_D;

  arb_state_e    state_reg, state_next;
  grant_e        last_reg, last_next;
  logic [BW-1:0] beats_reg, beats_next;
  logic          err_reg, err_next;

  // Port-indexed views: index 0 is the I-cache, index 1 the D-cache.
  logic [1:0]    port_req;
  logic [AW-1:0] port_addr [2];
  logic [1:0]    port_we;
  logic [DW-1:0] port_wd   [2];
  logic [1:0]    port_own;
  logic [1:0]    port_ready;
  logic [DW-1:0] port_rd   [2];

  logic          has_owner;
  logic          own_idx;
  logic          own_req;
  logic          pick_d;
  logic          pick_any;

  assign port_req     = {bus.d_req, bus.i_req};
  assign port_we      = {bus.d_we, bus.i_we};
  assign port_addr[0] = bus.i_addr;
  assign port_addr[1] = bus.d_addr;
  assign port_wd[0]   = bus.i_wd;
  assign port_wd[1]   = bus.d_wd;

  assign port_own  = {state_reg == OWN_D, state_reg == OWN_I};
  assign has_owner = |port_own;
  assign own_idx   = port_own[1];
  assign own_req   = port_req[own_idx];

  // Only the owning port sees memory responses; the other reads zero.
  for (genvar gi = 0; gi < 2; gi++) begin : g_port
    assign port_ready[gi] = port_own[gi] & bus.mready;
    assign port_rd[gi]    = port_own[gi] ? bus.mrd : '0;
  end

  assign bus.i_ready = port_ready[0];
  assign bus.d_ready = port_ready[1];
  assign bus.i_rd    = port_rd[0];
  assign bus.d_rd    = port_rd[1];

  assign bus.mreq  = has_owner & own_req;
  assign bus.maddr = has_owner ? port_addr[own_idx] : '0;
  assign bus.mwe   = has_owner & port_we[own_idx];
  assign bus.mwd   = has_owner ? port_wd[own_idx] : '0;

  assign bus.owner = owner_of(state_reg);
  assign bus.err   = err_reg;

  arb_pick2 u_pick (
    .req_i      (bus.i_req),
    .req_d      (bus.d_req),
    .last_grant (last_reg),
    .grant_d    (pick_d),
    .any        (pick_any)
  );

  always_comb begin
    state_next = state_reg;
    last_next  = last_reg;
    beats_next = beats_reg;
    err_next   = err_reg;
    case (state_reg)
      IDLE, TURN: begin
        // A beat with nobody granted is a memory-side protocol violation.
        if (bus.mready) begin
          err_next = 1'b1;
        end
        if (pick_any) begin
          state_next = pick_d ? OWN_D : OWN_I;
        end else begin
          state_next = IDLE;
        end
      end
      OWN_I, OWN_D: begin
        if (bus.mready) begin
          if (beats_reg == MAX_BEATS_W) begin
            err_next = 1'b1;
          end else begin
            beats_next = beats_reg + 1'b1;
          end
        end
        // A beat finishing in the same cycle as the drop delays release by one.
        if (!own_req && !bus.mready) begin
          state_next = TURN;
          last_next  = grant_e'(own_idx);
          beats_next = '0;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      last_reg  <= LAST_RESET;
      beats_reg <= '0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      last_reg  <= last_next;
      beats_reg <= beats_next;
      err_reg   <= err_next;
    end
  end

endmodule
